// File: rtl/bsk_mgr_common_param_pkg.sv
// Shared bsk_manager parameters and types used by the cut dispatch slice.
package bsk_mgr_common_param_pkg;

    localparam int unsigned BSK_CUT_NB = 4;
    localparam int unsigned DATA_W     = 64;

    // Counter width helper: $clog2 with a floor of one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? int'($clog2(v)) : 1;
    endfunction

    localparam int unsigned CUT_ID_W = clog2_min1(BSK_CUT_NB);

    typedef logic [CUT_ID_W-1:0] cut_id_t;
    typedef logic [DATA_W-1:0]   bsk_word_t;

endpackage

// File: rtl/bsk_mgr_cut_fifo.sv
// Per-lane synchronous FIFO; output valid follows the registered count, so a
// word pushed on one edge is presented from the next cycle on.
module bsk_mgr_cut_fifo
    import bsk_mgr_common_param_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             vld_o,
    input  logic             rdy_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned AW = clog2_min1(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pop_c;

    assign vld_o  = (cnt_q != '0);
    assign full_o = (cnt_q == CW'(DEPTH));
    assign pop_c  = vld_o & rdy_i;
    assign data_o = mem_q[rd_ptr_q];

    // Pointer and occupancy update; DEPTH is a power of 2 so pointers wrap freely.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_i, pop_c})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: contents are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bsk_mgr_cut_dispatch.sv
// Splits the loader BSK word stream into per-cut FIFO lanes and checks slice framing.
// Optional build macro BSK_MGR_CUT_DISPATCH_PERF_EN adds stall_cnt / slice_cnt outputs.
module bsk_mgr_cut_dispatch #(
    parameter int unsigned BSK_CUT_NB  = bsk_mgr_common_param_pkg::BSK_CUT_NB,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned CUT_WORD_NB = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         s_rst_n,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_sof,
    input  logic                         in_vld,
    output logic                         in_rdy,
    output logic [BSK_CUT_NB*DATA_W-1:0] out_data,
    output logic [BSK_CUT_NB-1:0]        out_vld,
    input  logic [BSK_CUT_NB-1:0]        out_rdy,
    output logic                         slice_done,
    output logic                         sof_err,
`ifdef BSK_MGR_CUT_DISPATCH_PERF_EN
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  slice_cnt,
`endif
    input  logic                         err_clr
);

    import bsk_mgr_common_param_pkg::clog2_min1;

    localparam int unsigned CUT_W  = clog2_min1(BSK_CUT_NB);
    localparam int unsigned WORD_W = clog2_min1(CUT_WORD_NB);

    logic [CUT_W-1:0]      cut_ptr_q, cut_ptr_d, tgt_cut_c;
    logic [WORD_W-1:0]     word_ptr_q, word_ptr_d, tgt_word_c;
    logic                  slice_done_q, slice_done_d;
    logic                  sof_err_q, sof_err_d;
    logic                  realign_c, accept_c, word_last_c, cut_last_c;
    logic [BSK_CUT_NB-1:0] lane_full;
    logic [BSK_CUT_NB-1:0] lane_push;

    // A misplaced SOF restarts the slice, so the word targets lane 0 / word 0.
    always_comb begin
        realign_c   = in_sof & ((cut_ptr_q != '0) | (word_ptr_q != '0));
        tgt_cut_c   = realign_c ? '0 : cut_ptr_q;
        tgt_word_c  = realign_c ? '0 : word_ptr_q;
        word_last_c = (tgt_word_c == WORD_W'(CUT_WORD_NB - 1));
        cut_last_c  = (tgt_cut_c == CUT_W'(BSK_CUT_NB - 1));
    end

    // Ready looks at the lane the word will actually land in; never at out_rdy.
    assign in_rdy   = ~lane_full[tgt_cut_c];
    assign accept_c = in_vld & in_rdy;

    always_comb begin
        cut_ptr_d    = cut_ptr_q;
        word_ptr_d   = word_ptr_q;
        slice_done_d = 1'b0;
        sof_err_d    = sof_err_q;
        if (accept_c) begin
            if (word_last_c) begin
                word_ptr_d = '0;
                cut_ptr_d  = cut_last_c ? '0 : tgt_cut_c + CUT_W'(1);
            end else begin
                word_ptr_d = tgt_word_c + WORD_W'(1);
                cut_ptr_d  = tgt_cut_c;
            end
            slice_done_d = word_last_c & cut_last_c;
        end
        if (err_clr) begin
            sof_err_d = 1'b0;
        end
        if (accept_c && realign_c) begin
            sof_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            cut_ptr_q    <= '0;
            word_ptr_q   <= '0;
            slice_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            cut_ptr_q    <= cut_ptr_d;
            word_ptr_q   <= word_ptr_d;
            slice_done_q <= slice_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign slice_done = slice_done_q;
    assign sof_err    = sof_err_q;

    for (genvar c = 0; c < BSK_CUT_NB; c++) begin : g_lane
        assign lane_push[c] = accept_c & (tgt_cut_c == CUT_W'(c));

        bsk_mgr_cut_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (DATA_W)
        ) u_fifo (
            .clk     (clk),
            .s_rst_n (s_rst_n),
            .push_i  (lane_push[c]),
            .data_i  (in_data),
            .full_o  (lane_full[c]),
            .vld_o   (out_vld[c]),
            .rdy_i   (out_rdy[c]),
            .data_o  (out_data[c*DATA_W +: DATA_W])
        );
    end

`ifdef BSK_MGR_CUT_DISPATCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] slice_cnt_q, slice_cnt_d;

    // Stall count saturates, slice count wraps; err_clr restarts both.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        slice_cnt_d = slice_cnt_q;
        if (in_vld && !in_rdy && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (slice_done_q) begin
            slice_cnt_d = slice_cnt_q + 32'd1;
        end
        if (err_clr) begin
            stall_cnt_d = '0;
            slice_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            stall_cnt_q <= '0;
            slice_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            slice_cnt_q <= slice_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign slice_cnt = slice_cnt_q;
`endif

endmodule

// File: tb/tb_bsk_mgr_cut_dispatch.sv
// Directed self-checking bench for bsk_mgr_cut_dispatch (4 lanes, 8 words/cut, depth 4).
module tb_bsk_mgr_cut_dispatch;

    localparam int unsigned NB = 4;
    localparam int unsigned DW = 64;

    logic              clk = 1'b0;
    logic              s_rst_n;
    logic [DW-1:0]     in_data;
    logic              in_sof;
    logic              in_vld;
    logic              in_rdy;
    logic [NB*DW-1:0]  out_data;
    logic [NB-1:0]     out_vld;
    logic [NB-1:0]     out_rdy;
    logic              slice_done;
    logic              sof_err;
    logic              err_clr;
`ifdef BSK_MGR_CUT_DISPATCH_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       slice_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    typedef struct packed {
        logic [1:0]    lane;
        logic [DW-1:0] d;
    } obs_t;

    obs_t obs[$];
    int   done_cyc[$];

    always #5 clk = ~clk;

    bsk_mgr_cut_dispatch dut (
        .clk        (clk),
        .s_rst_n    (s_rst_n),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .out_data   (out_data),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .slice_done (slice_done),
        .sof_err    (sof_err),
`ifdef BSK_MGR_CUT_DISPATCH_PERF_EN
        .stall_cnt  (stall_cnt),
        .slice_cnt  (slice_cnt),
`endif
        .err_clr    (err_clr)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every lane pop and slice_done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (s_rst_n === 1'b1) begin
            for (int c = 0; c < NB; c++) begin
                if (out_vld[c] && out_rdy[c]) obs.push_back({2'(c), out_data[c*DW +: DW]});
            end
            if (slice_done === 1'b1) done_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    function automatic int lane_cnt(input int lane);
        int n = 0;
        foreach (obs[i]) if (obs[i].lane == 2'(lane)) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] lane_word(input int lane, input int idx);
        int n = 0;
        foreach (obs[i]) begin
            if (obs[i].lane == 2'(lane)) begin
                if (n == idx) return obs[i].d;
                n++;
            end
        end
        return 'x;
    endfunction

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic do_reset();
        s_rst_n = 1'b0;
        in_vld  = 1'b0;
        in_sof  = 1'b0;
        in_data = '0;
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        s_rst_n = 1'b1;
        obs.delete();
        done_cyc.delete();
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic sof);
        int t = 0;
        in_data = d;
        in_sof  = sof;
        in_vld  = 1'b1;
        @(negedge clk);
        while (in_rdy !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %0h not accepted, got in_rdy=%b required 1", d, in_rdy);
        end
        last_acc = cyc + 1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        out_rdy = '1;
        @(negedge clk);
        checks++; if (out_vld !== 4'b0000) begin errors++; $display("FAIL reset_out_vld: got %b required 0000", out_vld); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b required 1", in_rdy); end
        checks++; if (slice_done !== 1'b0) begin errors++; $display("FAIL reset_slice_done: got %b required 0", slice_done); end
        checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL reset_sof_err: got %b required 0", sof_err); end
        checks++; if (dut.cut_ptr_q !== 2'd0 || dut.word_ptr_q !== 3'd0) begin
            errors++; $display("FAIL reset_ptrs: got cut=%0d word=%0d required 0/0", dut.cut_ptr_q, dut.word_ptr_q);
        end
        @(posedge clk);
        #1;
    endtask

    // One full slice base..base+31 with all lanes ready, then checks routing.
    task automatic smooth_slice(input int base, input string tag);
        int acc31;
        out_rdy = '1;
        for (int w = 0; w < 32; w++) send_word(64'(base + w), w == 0);
        acc31 = last_acc;
        idle(4);
        for (int c = 0; c < NB; c++) begin
            checks++;
            if (lane_cnt(c) !== 8) begin errors++; $display("FAIL %s_lane%0d_count: got %0d required 8", tag, c, lane_cnt(c)); end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (lane_word(c, i) !== 64'(base + c*8 + i)) begin
                    errors++; $display("FAIL %s_lane%0d_word%0d: got %0h required %0h", tag, c, i, lane_word(c, i), base + c*8 + i);
                end
            end
        end
        checks++; if (done_cyc.size() !== 1) begin errors++; $display("FAIL %s_done_count: got %0d required 1", tag, done_cyc.size()); end
        checks++; if ((done_cyc.size() > 0 ? done_cyc[0] : -1) !== acc31) begin
            errors++; $display("FAIL %s_done_cycle: got %0d required %0d", tag, done_cyc.size() > 0 ? done_cyc[0] : -1, acc31);
        end
        checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL %s_sof_err: got %b required 0", tag, sof_err); end
    endtask

    task automatic test_smooth_slice();
        do_reset();
        smooth_slice(0, "smooth");
    endtask

    task automatic test_backpressure();
        do_reset();
        out_rdy = 4'b1101;
        for (int w = 0; w < 12; w++) send_word(64'(100 + w), w == 0);
        @(negedge clk);
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy_drop: got %b required 0", in_rdy); end
        checks++; if (out_vld[1] !== 1'b1) begin errors++; $display("FAIL bp_lane1_vld: got %b required 1", out_vld[1]); end
        @(posedge clk);
        #1;
        idle(3);
        @(negedge clk);
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy_hold: got %b required 0", in_rdy); end
        checks++; if (lane_cnt(0) !== 8 || lane_cnt(1) !== 0) begin
            errors++; $display("FAIL bp_partial: got lane0=%0d lane1=%0d required 8/0", lane_cnt(0), lane_cnt(1));
        end
        @(posedge clk);
        #1;
        out_rdy = '1;
        for (int w = 12; w < 32; w++) send_word(64'(100 + w), 1'b0);
        idle(6);
        for (int c = 0; c < NB; c++) begin
            checks++;
            if (lane_cnt(c) !== 8) begin errors++; $display("FAIL bp_lane%0d_count: got %0d required 8", c, lane_cnt(c)); end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (lane_word(c, i) !== 64'(100 + c*8 + i)) begin
                    errors++; $display("FAIL bp_lane%0d_word%0d: got %0h required %0h", c, i, lane_word(c, i), 100 + c*8 + i);
                end
            end
        end
        checks++; if (done_cyc.size() !== 1) begin errors++; $display("FAIL bp_done_count: got %0d required 1", done_cyc.size()); end
    endtask

    task automatic test_framing();
        int exp_w;
        do_reset();
        out_rdy = '1;
        for (int w = 0; w < 5; w++) send_word(64'(200 + w), w == 0);
        send_word(64'(205), 1'b1);
        @(negedge clk);
        checks++; if (sof_err !== 1'b1) begin errors++; $display("FAIL frm_sof_err_set: got %b required 1", sof_err); end
        checks++; if (dut.cut_ptr_q !== 2'd0 || dut.word_ptr_q !== 3'd1) begin
            errors++; $display("FAIL frm_realign: got cut=%0d word=%0d required 0/1", dut.cut_ptr_q, dut.word_ptr_q);
        end
        @(posedge clk);
        #1;
        for (int w = 206; w < 237; w++) send_word(64'(w), 1'b0);
        idle(4);
        checks++; if (lane_cnt(0) !== 13) begin errors++; $display("FAIL frm_lane0_count: got %0d required 13", lane_cnt(0)); end
        for (int i = 0; i < 13; i++) begin
            exp_w = (i < 5) ? 200 + i : 205 + (i - 5);
            checks++;
            if (lane_word(0, i) !== 64'(exp_w)) begin errors++; $display("FAIL frm_lane0_word%0d: got %0h required %0h", i, lane_word(0, i), exp_w); end
        end
        for (int c = 1; c < NB; c++) begin
            checks++;
            if (lane_word(c, 0) !== 64'(213 + (c-1)*8) || lane_word(c, 7) !== 64'(220 + (c-1)*8)) begin
                errors++; $display("FAIL frm_lane%0d_ends: got %0h..%0h required %0h..%0h", c, lane_word(c, 0), lane_word(c, 7), 213 + (c-1)*8, 220 + (c-1)*8);
            end
        end
        checks++; if (done_cyc.size() !== 1) begin errors++; $display("FAIL frm_done_count: got %0d required 1", done_cyc.size()); end
        checks++; if (sof_err !== 1'b1) begin errors++; $display("FAIL frm_sticky: got %b required 1", sof_err); end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL frm_err_clr: got %b required 0", sof_err); end
        @(posedge clk);
        #1;
        send_word(64'(300), 1'b0);
        err_clr = 1'b1;
        send_word(64'(301), 1'b1);
        err_clr = 1'b0;
        @(negedge clk);
        checks++; if (sof_err !== 1'b1) begin errors++; $display("FAIL frm_set_over_clr: got %b required 1", sof_err); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_push_pop();
        do_reset();
        out_rdy = 4'b0000;
        for (int w = 0; w < 4; w++) send_word(64'(400 + w), w == 0);
        @(negedge clk);
        checks++; if (dut.g_lane[0].u_fifo.cnt_q !== 3'd4) begin errors++; $display("FAIL pp_full_cnt: got %0d required 4", dut.g_lane[0].u_fifo.cnt_q); end
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL pp_full_rdy: got %b required 0", in_rdy); end
        @(posedge clk);
        #1;
        in_data = 64'(404);
        in_vld  = 1'b1;
        out_rdy = 4'b0001;
        @(negedge clk);
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL pp_rdy_registered: got %b required 0", in_rdy); end
        @(posedge clk);
        #1;
        for (int w = 4; w < 8; w++) begin
            send_word(64'(400 + w), 1'b0);
            checks++;
            if (dut.g_lane[0].u_fifo.cnt_q !== 3'd3) begin errors++; $display("FAIL pp_cnt_hold_w%0d: got %0d required 3", w, dut.g_lane[0].u_fifo.cnt_q); end
        end
        idle(5);
        checks++; if (lane_cnt(0) !== 8) begin errors++; $display("FAIL pp_lane0_count: got %0d required 8", lane_cnt(0)); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (lane_word(0, i) !== 64'(400 + i)) begin errors++; $display("FAIL pp_lane0_word%0d: got %0h required %0h", i, lane_word(0, i), 400 + i); end
        end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        out_rdy = '1;
        for (int w = 0; w < 13; w++) send_word(64'(450 + w), w == 0);
        do_reset();
        @(negedge clk);
        checks++; if (out_vld !== 4'b0000) begin errors++; $display("FAIL mrst_out_vld: got %b required 0000", out_vld); end
        checks++; if (dut.cut_ptr_q !== 2'd0 || dut.word_ptr_q !== 3'd0) begin
            errors++; $display("FAIL mrst_ptrs: got cut=%0d word=%0d required 0/0", dut.cut_ptr_q, dut.word_ptr_q);
        end
        @(posedge clk);
        #1;
        smooth_slice(500, "mrst");
    endtask

    task automatic test_back_to_back();
        int acc_a;
        int acc_b;
        do_reset();
        out_rdy = '1;
        for (int w = 0; w < 64; w++) begin
            send_word(64'(600 + w), w == 0);
            if (w == 31) acc_a = last_acc;
        end
        acc_b = last_acc;
        idle(4);
        checks++; if (done_cyc.size() !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d required 2", done_cyc.size()); end
        checks++; if (done_cyc.size() != 2 || done_cyc[0] !== acc_a || done_cyc[1] !== acc_b) begin
            errors++; $display("FAIL b2b_done_cycles: got %0d pulses required at %0d and %0d", done_cyc.size(), acc_a, acc_b);
        end
        checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL b2b_sof_err: got %b required 0", sof_err); end
        for (int c = 0; c < NB; c++) begin
            checks++;
            if (lane_cnt(c) !== 16 || lane_word(c, 8) !== 64'(632 + c*8) || lane_word(c, 15) !== 64'(639 + c*8)) begin
                errors++; $display("FAIL b2b_lane%0d: got count %0d word8 %0h required 16 / %0h", c, lane_cnt(c), lane_word(c, 8), 632 + c*8);
            end
        end
    endtask

`ifdef BSK_MGR_CUT_DISPATCH_PERF_EN
    task automatic test_perf();
        do_reset();
        out_rdy = 4'b1110;
        for (int w = 0; w < 4; w++) send_word(64'(w), w == 0);
        in_data = 64'(4);
        in_vld  = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        out_rdy = '1;
        for (int w = 4; w < 96; w++) send_word(64'(w), (w % 32) == 0);
        idle(4);
        checks++; if (slice_cnt !== 32'd3) begin errors++; $display("FAIL perf_slice_cnt: got %0d required 3", slice_cnt); end
        checks++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL perf_stall_cnt: got %0d required 10", stall_cnt); end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checks++; if (slice_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_clear: got slice=%0d stall=%0d required 0/0", slice_cnt, stall_cnt);
        end
    endtask
`endif

    initial begin
        out_rdy = '1;
        test_reset();
        test_smooth_slice();
        test_backpressure();
        test_framing();
        test_push_pop();
        test_midstream_reset();
        test_back_to_back();
`ifdef BSK_MGR_CUT_DISPATCH_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
